// File: rtl/memory_access_unit.sv
// Memory access unit: turns controller load/store/fetch requests into
// single-word external bus transactions, with lane steering on the way out
// and byte/half extraction plus sign/zero extension on the way back.
module memory_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_enable,
  input  logic        memory_command,
  input  logic        fetch,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [2:0]  load_memory_decoder_type,
  input  logic [1:0]  store_memory_encoder_type,
  output logic        memory_ready,
  output logic        memory_valid,
  output logic [31:0] read_data,
  output logic        misaligned_exception,
  output logic        bus_request,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_enable,
  output logic [31:0] bus_write_data,
  input  logic        bus_ack,
  input  logic [31:0] bus_read_data
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, REQUEST, RESPONSE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          cmd_q, cmd_d;
  logic          fetch_q, fetch_d;
  logic [1:0]    size_q, size_d;
  logic          unsigned_q, unsigned_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [1:0]    req_size_c;
  logic [3:0]    be_c;
  logic [7:0]    rd_byte_c;
  logic [15:0]   rd_half_c;
  logic [DW-1:0] rd_decoded_c;

  // Access size of the incoming request and its alignment check
  always_comb begin
    req_size_c = SZ_WORD;
    if (!fetch) begin
      if (memory_command) begin
        case (store_memory_encoder_type)
          2'b00:   req_size_c = SZ_BYTE;
          2'b01:   req_size_c = SZ_HALF;
          default: req_size_c = SZ_WORD;
        endcase
      end else begin
        case (load_memory_decoder_type[1:0])
          2'b00:   req_size_c = SZ_BYTE;
          2'b01:   req_size_c = SZ_HALF;
          default: req_size_c = SZ_WORD;
        endcase
      end
    end
    misaligned_exception = 1'b0;
    if (req_size_c == SZ_HALF) misaligned_exception = address[0];
    if (req_size_c == SZ_WORD) misaligned_exception = (address[1:0] != 2'b00);
  end

  // Lane enables and replicated store data from the latched request
  always_comb begin
    case (size_q)
      SZ_BYTE: begin
        be_c           = 4'b0001 << addr_q[1:0];
        bus_write_data = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        be_c           = 4'b0011 << addr_q[1:0];
        bus_write_data = {2{wdata_q[15:0]}};
      end
      default: begin
        be_c           = 4'b1111;
        bus_write_data = wdata_q;
      end
    endcase
    bus_address = {addr_q[AW-1:2], 2'b00};
  end

  // Extract and extend the addressed byte/half from the returned bus word
  always_comb begin
    case (addr_q[1:0])
      2'd0:    rd_byte_c = bus_read_data[7:0];
      2'd1:    rd_byte_c = bus_read_data[15:8];
      2'd2:    rd_byte_c = bus_read_data[23:16];
      default: rd_byte_c = bus_read_data[31:24];
    endcase
    rd_half_c = addr_q[1] ? bus_read_data[31:16] : bus_read_data[15:0];
    case (size_q)
      SZ_BYTE: rd_decoded_c = unsigned_q ? {24'b0, rd_byte_c}
                                         : {{24{rd_byte_c[7]}}, rd_byte_c};
      SZ_HALF: rd_decoded_c = unsigned_q ? {16'b0, rd_half_c}
                                         : {{16{rd_half_c[15]}}, rd_half_c};
      default: rd_decoded_c = bus_read_data;
    endcase
  end

  // Next-state, request latching and status/bus strobes
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cmd_d           = cmd_q;
    fetch_d         = fetch_q;
    size_d          = size_q;
    unsigned_d      = unsigned_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    memory_ready    = 1'b0;
    memory_valid    = 1'b0;
    bus_request     = 1'b0;
    bus_write       = 1'b0;
    bus_byte_enable = 4'b0000;
    case (state_q)
      IDLE: begin
        memory_ready = 1'b1;
        if (memory_enable && !misaligned_exception) begin
          addr_d     = address;
          cmd_d      = memory_command;
          fetch_d    = fetch;
          size_d     = req_size_c;
          unsigned_d = !fetch && load_memory_decoder_type[2];
          wdata_d    = write_data;
          state_d    = REQUEST;
        end
      end
      REQUEST: begin
        bus_request     = 1'b1;
        bus_write       = cmd_q && !fetch_q;
        bus_byte_enable = be_c;
        if (bus_ack) begin
          if (!cmd_q || fetch_q) rdata_d = rd_decoded_c;
          state_d = RESPONSE;
        end
      end
      RESPONSE: begin
        memory_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cmd_q      <= 1'b0;
      fetch_q    <= 1'b0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cmd_q      <= cmd_d;
      fetch_q    <= fetch_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign read_data = rdata_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: directed scenarios plus randomized
// load/store/fetch traffic checked against an arithmetic reference model.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        memory_enable;
  logic        memory_command;
  logic        fetch;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [2:0]  load_memory_decoder_type;
  logic [1:0]  store_memory_encoder_type;
  logic        memory_ready;
  logic        memory_valid;
  logic [31:0] read_data;
  logic        misaligned_exception;
  logic        bus_request;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_write_data;
  logic        bus_ack;
  logic [31:0] bus_read_data;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_rd = 32'd0;

  memory_access_unit dut (
    .clk                       (clk),
    .reset                     (reset),
    .memory_enable             (memory_enable),
    .memory_command            (memory_command),
    .fetch                     (fetch),
    .address                   (address),
    .write_data                (write_data),
    .load_memory_decoder_type  (load_memory_decoder_type),
    .store_memory_encoder_type (store_memory_encoder_type),
    .memory_ready              (memory_ready),
    .memory_valid              (memory_valid),
    .read_data                 (read_data),
    .misaligned_exception      (misaligned_exception),
    .bus_request               (bus_request),
    .bus_write                 (bus_write),
    .bus_address               (bus_address),
    .bus_byte_enable           (bus_byte_enable),
    .bus_write_data            (bus_write_data),
    .bus_ack                   (bus_ack),
    .bus_read_data             (bus_read_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Number of bytes touched by an access
  function automatic logic [31:0] nbytes(input logic f, input logic cmd,
                                         input logic [2:0] lt, input logic [1:0] st);
    logic [1:0] code;
    if (f) return 32'd4;
    code = cmd ? st : lt[1:0];
    if (code == 2'd0) return 32'd1;
    if (code == 2'd1) return 32'd2;
    return 32'd4;
  endfunction

  function automatic logic exp_mis(input logic f, input logic cmd, input logic [2:0] lt,
                                   input logic [1:0] st, input logic [31:0] a);
    return (a % nbytes(f, cmd, lt, st)) != 32'd0;
  endfunction

  function automatic logic [31:0] exp_be(input logic [31:0] nb, input logic [31:0] a);
    logic [31:0] m;
    m = ((32'd1 << nb) - 32'd1) << (a % 32'd4);
    return m & 32'hF;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [31:0] nb, input logic [31:0] wd);
    logic [31:0] r;
    logic [31:0] s;
    r = 32'd0;
    for (int i = 0; i < 4; i++) begin
      s = wd >> (32'd8 * (32'(i) % nb));
      r[8*i +: 8] = s[7:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] nb, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] rw);
    logic [31:0] mask;
    logic [31:0] v;
    if (nb == 32'd4) return rw;
    mask = (32'd1 << (32'd8 * nb)) - 32'd1;
    v = (rw >> (32'd8 * (a % 32'd4))) & mask;
    if (sgn && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // Randomize controller inputs while a request is in flight; alignment is checked on them
  task automatic scramble();
    memory_enable             = 1'($urandom);
    memory_command            = 1'($urandom);
    fetch                     = 1'($urandom);
    address                   = $urandom;
    write_data                = $urandom;
    load_memory_decoder_type  = 3'($urandom);
    store_memory_encoder_type = 2'($urandom);
    #1;
    check("misaligned_busy", 32'(misaligned_exception),
          32'(exp_mis(fetch, memory_command, load_memory_decoder_type,
                      store_memory_encoder_type, address)));
  endtask

  // One complete access through the controller port
  task automatic do_access(input logic f, input logic cmd, input logic [2:0] lt,
                           input logic [1:0] st, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rw, input int delay);
    logic [31:0] nb;
    logic        mis;
    logic        wr;
    nb  = nbytes(f, cmd, lt, st);
    mis = (a % nb) != 32'd0;
    wr  = cmd && !f;
    fetch = f; memory_command = cmd; load_memory_decoder_type = lt;
    store_memory_encoder_type = st; address = a; write_data = wd;
    memory_enable = 1'b1;
    #1;
    check("misaligned", 32'(misaligned_exception), 32'(mis));
    check("ready_idle", 32'(memory_ready), 32'd1);
    tick();
    memory_enable = 1'b0;
    #1;
    if (mis) begin
      check("no_request", 32'(bus_request), 32'd0);
      check("ready_stays", 32'(memory_ready), 32'd1);
      return;
    end
    for (int i = 0; i <= delay; i++) begin
      check("bus_request", 32'(bus_request), 32'd1);
      check("bus_address", bus_address, a & 32'hFFFF_FFFC);
      check("bus_byte_enable", 32'(bus_byte_enable), exp_be(nb, a));
      check("bus_write", 32'(bus_write), 32'(wr));
      if (wr) check("bus_write_data", bus_write_data, exp_wd(nb, wd));
      check("ready_busy", 32'(memory_ready), 32'd0);
      check("valid_early", 32'(memory_valid), 32'd0);
      if (i < delay) begin
        scramble();
        tick();
      end
    end
    bus_ack = 1'b1;
    bus_read_data = rw;
    tick();
    bus_ack = 1'($urandom);
    bus_read_data = $urandom;
    if (!wr) exp_rd = exp_load(nb, !lt[2] && !f, a, rw);
    scramble();
    check("valid_pulse", 32'(memory_valid), 32'd1);
    check("read_data", read_data, exp_rd);
    check("req_dropped", 32'(bus_request), 32'd0);
    check("be_idle", 32'(bus_byte_enable), 32'd0);
    check("ready_resp", 32'(memory_ready), 32'd0);
    tick();
    memory_enable = 1'b0;
    bus_ack = 1'b0;
    #1;
    check("valid_single", 32'(memory_valid), 32'd0);
    check("ready_back", 32'(memory_ready), 32'd1);
    check("read_data_hold", read_data, exp_rd);
  endtask

  initial begin
    reset = 1'b1; memory_enable = 1'b0; memory_command = 1'b0; fetch = 1'b0;
    address = 32'd0; write_data = 32'd0; load_memory_decoder_type = 3'd0;
    store_memory_encoder_type = 2'd0; bus_ack = 1'b0; bus_read_data = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_ready", 32'(memory_ready), 32'd1);
    check("rst_valid", 32'(memory_valid), 32'd0);
    check("rst_request", 32'(bus_request), 32'd0);
    check("rst_write", 32'(bus_write), 32'd0);
    check("rst_be", 32'(bus_byte_enable), 32'd0);
    check("rst_read_data", read_data, 32'd0);

    // Fetch with a three-cycle bus latency
    do_access(1'b1, 1'b0, 3'b000, 2'b00, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    check("fetch_word", read_data, 32'hDEADBEEF);
    // Signed/unsigned sub-word loads
    do_access(1'b0, 1'b0, 3'b000, 2'b00, 32'h103, 32'h0, 32'h80FF0000, 0);
    check("lb_sign", read_data, 32'hFFFFFF80);
    do_access(1'b0, 1'b0, 3'b100, 2'b00, 32'h103, 32'h0, 32'h80FF0000, 1);
    check("lbu_zero", read_data, 32'h00000080);
    do_access(1'b0, 1'b0, 3'b001, 2'b00, 32'h102, 32'h0, 32'h80FF0000, 0);
    check("lh_sign", read_data, 32'hFFFF80FF);
    // Byte store leaves read_data alone
    do_access(1'b0, 1'b1, 3'b000, 2'b00, 32'h201, 32'h000000AB, 32'h12345678, 2);
    check("sb_keeps_rd", read_data, 32'hFFFF80FF);
    // Misaligned word load and half store are dropped; aligned word store is legal
    do_access(1'b0, 1'b0, 3'b010, 2'b00, 32'h102, 32'h0, 32'h0, 0);
    do_access(1'b0, 1'b1, 3'b000, 2'b01, 32'h301, 32'h5555, 32'h0, 0);
    do_access(1'b0, 1'b1, 3'b000, 2'b10, 32'h300, 32'hCAFEF00D, 32'h0, 1);

    // Reset while waiting on the bus aborts the access
    fetch = 1'b1; memory_command = 1'b0; address = 32'h400; memory_enable = 1'b1;
    tick();
    memory_enable = 1'b0;
    tick();
    check("abort_pending", 32'(bus_request), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_rd = 32'd0;
    check("abort_request", 32'(bus_request), 32'd0);
    check("abort_valid", 32'(memory_valid), 32'd0);
    check("abort_ready", 32'(memory_ready), 32'd1);
    check("abort_read_data", read_data, 32'd0);
    bus_ack = 1'b1;
    bus_read_data = 32'hFFFFFFFF;
    tick();
    bus_ack = 1'b0;
    check("late_ack_valid", 32'(memory_valid), 32'd0);
    check("late_ack_request", 32'(bus_request), 32'd0);
    check("late_ack_rd", read_data, 32'd0);
    do_access(1'b1, 1'b0, 3'b000, 2'b00, 32'h404, 32'h0, 32'h0BADF00D, 0);
    check("fetch_after_abort", read_data, 32'h0BADF00D);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      do_access(($urandom_range(0, 7) == 0), 1'($urandom), 3'($urandom), 2'($urandom),
                a, $urandom, $urandom, $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
